// File: rtl/qspi_xip_cache_pkg.sv
// Shared constants and FSM encoding for the QSPI XIP read cache.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package qspi_xip_cache_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/xip_cache_store.sv
// Valid/tag/data storage for the direct-mapped XIP cache.
// Latency: combinational read; writes take effect on the next HCLK edge.
// Backpressure: none; the controller alone decides when to write.
//
// Ports:
//   HCLK, HRESETn              clock, async active-low reset (clears valid bits)
//   inv                        clear every valid bit (wins over tv_en)
//   rd_idx, rd_word            read address -> rd_valid, rd_tag, rd_data
//   wr_en, wr_idx, wr_word,    one-word write used while filling a line
//   wr_data
//   tv_en, tv_idx, tv_tag      write tag and set valid for a line
import qspi_xip_cache_pkg::*;

module xip_cache_store #(
  parameter int NUM_LINES  = 32,
  parameter int LINE_WORDS = 4,
  parameter int TAG_W      = 23
) (
  input  logic                          HCLK,
  input  logic                          HRESETn,
  input  logic                          inv,
  input  logic [$clog2(NUM_LINES)-1:0]  rd_idx,
  input  logic [$clog2(LINE_WORDS)-1:0] rd_word,
  output logic                          rd_valid,
  output logic [TAG_W-1:0]              rd_tag,
  output logic [31:0]                   rd_data,
  input  logic                          wr_en,
  input  logic [$clog2(NUM_LINES)-1:0]  wr_idx,
  input  logic [$clog2(LINE_WORDS)-1:0] wr_word,
  input  logic [31:0]                   wr_data,
  input  logic                          tv_en,
  input  logic [$clog2(NUM_LINES)-1:0]  tv_idx,
  input  logic [TAG_W-1:0]              tv_tag
);

  logic [NUM_LINES-1:0] valid;
  logic [TAG_W-1:0]     tags [NUM_LINES];
  logic [31:0]          data [NUM_LINES][LINE_WORDS];

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      valid <= '0;
    end else if (inv) begin
      valid <= '0;
    end else if (tv_en) begin
      valid[tv_idx] <= 1'b1;
    end
  end

  // Tag and data arrays carry no reset; the valid bits guard them.
  always_ff @(posedge HCLK) begin
    if (tv_en) tags[tv_idx] <= tv_tag;
    if (wr_en) data[wr_idx][wr_word] <= wr_data;
  end

  assign rd_valid = valid[rd_idx];
  assign rd_tag   = tags[rd_idx];
  assign rd_data  = data[rd_idx][rd_word];

endmodule

// File: rtl/qspi_xip_cache.sv
// Direct-mapped read cache between the CPU AHB-Lite bus and the QSPI XIP controller.
// Latency: hit 0 wait states; miss LINE_WORDS x XIP beat latency + 1 wait states.
// Backpressure: HREADYOUT low for the whole line fill; fill advances only on M_HREADY.
//
// Ports: CPU-side AHB-Lite slave (HSEL, HREADY, HTRANS, HSIZE, HWRITE, HADDR ->
// HREADYOUT, HRDATA), INV invalidate-all pulse, flash-side AHB-Lite master
// (M_HADDR, M_HTRANS, M_HSIZE, M_HWRITE <- M_HRDATA, M_HREADY).
// Optional: define QSPI_XIP_CACHE_STATS_EN for HIT_CNT/MISS_CNT outputs.
import qspi_xip_cache_pkg::*;

module qspi_xip_cache #(
  parameter int NUM_LINES  = 32,
  parameter int LINE_WORDS = 4
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic        HREADY,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic        HWRITE,
  input  logic [31:0] HADDR,
  output logic        HREADYOUT,
  output logic [31:0] HRDATA,
  input  logic        INV,
  output logic [31:0] M_HADDR,
  output logic [1:0]  M_HTRANS,
  output logic [2:0]  M_HSIZE,
  output logic        M_HWRITE,
  input  logic [31:0] M_HRDATA,
  input  logic        M_HREADY
`ifdef QSPI_XIP_CACHE_STATS_EN
  ,
  output logic [31:0] HIT_CNT,
  output logic [31:0] MISS_CNT
`endif
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = 30 - OFF_W - IDX_W;
  localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(LINE_WORDS - 1);

  state_t state, state_nx;

  // Registered CPU address phase.
  logic        dp_vld, dp_write;
  logic [31:0] dp_addr;

  logic [OFF_W-1:0] dp_word, a_cnt, d_cnt;
  logic [IDX_W-1:0] dp_idx;
  logic [TAG_W-1:0] dp_tag, rd_tag;
  logic             rd_valid, dp_rd, hit, miss;
  logic [31:0]      rd_data, resp_word;
  logic             a_done, d_pend, inv_pending;
  logic             issue, beat_cap, last_beat, tv_en;
  logic             unused_bits;

  assign dp_word = dp_addr[OFF_W+1:2];
  assign dp_idx  = dp_addr[OFF_W+2 +: IDX_W];
  assign dp_tag  = dp_addr[31 -: TAG_W];
  assign dp_rd   = dp_vld & ~dp_write;
  assign hit     = dp_rd & rd_valid & (rd_tag == dp_tag);
  assign miss    = (state == S_IDLE) & dp_rd & ~hit;

  // Beat 0 goes out in the miss cycle itself so the stall is LINE_WORDS beats + 1.
  assign issue     = miss | ((state == S_FILL) & ~a_done);
  assign beat_cap  = (state == S_FILL) & d_pend & M_HREADY;
  assign last_beat = beat_cap & (d_cnt == LAST_WORD);
  // A same-edge INV also blocks the line from becoming valid.
  assign tv_en     = last_beat & ~inv_pending & ~INV;

  assign unused_bits = ^{HSIZE, HTRANS[0], dp_addr[1:0]};

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_vld   <= 1'b0;
      dp_write <= 1'b0;
      dp_addr  <= '0;
    end else if (HREADY) begin
      dp_vld   <= HSEL & HTRANS[1];
      dp_write <= HWRITE;
      dp_addr  <= HADDR;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state <= S_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (miss) state_nx = S_FILL;
      S_FILL:  if (last_beat) state_nx = S_RESP;
      S_RESP:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Pipelined fill: a_cnt tracks address phases, d_cnt tracks data phases.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      a_cnt       <= '0;
      d_cnt       <= '0;
      a_done      <= 1'b0;
      d_pend      <= 1'b0;
      inv_pending <= 1'b0;
      resp_word   <= '0;
    end else begin
      if (last_beat) begin
        a_cnt  <= '0;
        d_cnt  <= '0;
        a_done <= 1'b0;
        d_pend <= 1'b0;
      end else if (M_HREADY && (issue || d_pend)) begin
        d_pend <= issue;
        if (issue) begin
          if (a_cnt == LAST_WORD) a_done <= 1'b1;
          else                    a_cnt  <= a_cnt + 1'b1;
        end
        if (d_pend) d_cnt <= d_cnt + 1'b1;
      end
      if (beat_cap && (d_cnt == dp_word)) resp_word <= M_HRDATA;
      if (state_nx != S_FILL)              inv_pending <= 1'b0;
      else if (INV && (state == S_FILL))   inv_pending <= 1'b1;
    end
  end

  assign M_HTRANS = issue ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign M_HADDR  = issue ? {dp_addr[31:OFF_W+2], a_cnt, 2'b00} : 32'h0;
  assign M_HSIZE  = HSIZE_WORD;
  assign M_HWRITE = 1'b0;

  always_comb begin
    HREADYOUT = 1'b1;
    HRDATA    = 32'h0;
    if (state == S_FILL || miss) HREADYOUT = 1'b0;
    if (state == S_RESP)         HRDATA = resp_word;
    else if (hit)                HRDATA = rd_data;
  end

  xip_cache_store #(
    .NUM_LINES (NUM_LINES),
    .LINE_WORDS(LINE_WORDS),
    .TAG_W     (TAG_W)
  ) u_store (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .inv     (INV),
    .rd_idx  (dp_idx),
    .rd_word (dp_word),
    .rd_valid(rd_valid),
    .rd_tag  (rd_tag),
    .rd_data (rd_data),
    .wr_en   (beat_cap),
    .wr_idx  (dp_idx),
    .wr_word (d_cnt),
    .wr_data (M_HRDATA),
    .tv_en   (tv_en),
    .tv_idx  (dp_idx),
    .tv_tag  (dp_tag)
  );

`ifdef QSPI_XIP_CACHE_STATS_EN
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      HIT_CNT  <= '0;
      MISS_CNT <= '0;
    end else begin
      if ((state == S_IDLE) && hit && (HIT_CNT != 32'hFFFF_FFFF)) HIT_CNT <= HIT_CNT + 1'b1;
      if (miss && (MISS_CNT != 32'hFFFF_FFFF))                    MISS_CNT <= MISS_CNT + 1'b1;
    end
  end
`endif

endmodule
